// File: rtl/bcd_stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch controller and its surroundings.
// Latency: none, wires only.
// Backpressure: none; pulse-based signalling with no ready path.
interface bcd_stopwatch_ctrl_if;
   logic       start_stop;
   logic       lap;
   logic       clear;
   logic [7:0] bcd_in;
   logic       cnt_en;
   logic       cnt_clr;
   logic       running;
   logic       lap_active;
   logic [7:0] disp_bcd;
   logic       scan_sel;
   logic [3:0] scan_digit;
   logic       overflow;

   // The controller side: takes button pulses and the live count.
   modport slave (
      input  start_stop, lap, clear, bcd_in,
      output cnt_en, cnt_clr, running, lap_active, disp_bcd, scan_sel, scan_digit, overflow
   );

   // The surrounding side: buttons, counter datapath and display driver.
   modport master (
      output start_stop, lap, clear, bcd_in,
      input  cnt_en, cnt_clr, running, lap_active, disp_bcd, scan_sel, scan_digit, overflow
   );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/lap/clear controller for a two-digit BCD stopwatch with a scanned display.
// Latency: state, cnt_en, cnt_clr and overflow are registered (one cycle after cause).
// Backpressure: none; pulses arriving in a state that does not accept them are dropped.
module bcd_stopwatch_ctrl #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned SCAN_DIV = 50_000
) (
   input  logic                clk_i,
   input  logic                reset_i,
   bcd_stopwatch_ctrl_if.slave bus
);

   localparam int unsigned P_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned S_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [P_W-1:0] P_LAST = P_W'(TICK_DIV - 1);
   localparam logic [S_W-1:0] S_LAST = S_W'(SCAN_DIV - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_LAP   = 2'd2;
   localparam logic [1:0] ST_PAUSE = 2'd3;

   logic [1:0]     state_q, state_d;
   logic [P_W-1:0] p_q, p_d;
   logic [S_W-1:0] scan_q, scan_d;
   logic           scan_sel_q, scan_sel_d;
   logic [7:0]     lap_q, lap_d;
   logic           cnt_en_q, cnt_en_d;
   logic           cnt_clr_q, cnt_clr_d;
   logic           ovf_q, ovf_d;
   logic           run_now;
   logic           tick;
   logic [7:0]     disp;

   assign run_now = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign tick    = run_now && (p_q == P_LAST);

   // FSM transitions, lap snapshot and clear request; priorities resolve simultaneous pulses
   always_comb begin
      state_d   = state_q;
      lap_d     = lap_q;
      cnt_clr_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.clear)           cnt_clr_d = 1'b1;
            else if (bus.start_stop) state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (bus.start_stop) state_d = ST_PAUSE;
            else if (bus.lap) begin
               state_d = ST_LAP;
               lap_d   = bus.bcd_in;
            end
         end
         ST_LAP: begin
            if (bus.start_stop) state_d = ST_PAUSE;
            else if (bus.lap)   state_d = ST_RUN;
         end
         ST_PAUSE: begin
            if (bus.clear) begin
               state_d   = ST_IDLE;
               cnt_clr_d = 1'b1;
            end else if (bus.start_stop) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Prescaler advances only while running, holds in pause, zeroed in idle; wrap schedules cnt_en
   always_comb begin
      p_d = p_q;
      if (state_q == ST_IDLE) p_d = '0;
      else if (run_now)       p_d = tick ? '0 : p_q + 1'b1;
      cnt_en_d = tick;
      ovf_d    = cnt_en_q && (bus.bcd_in == 8'h99);
   end

   // Free-running digit scan: each digit dwells SCAN_DIV cycles
   always_comb begin
      scan_d     = (scan_q == S_LAST) ? '0 : scan_q + 1'b1;
      scan_sel_d = scan_sel_q ^ (scan_q == S_LAST);
   end

   // State registers; reset wins over any pulse present in the same cycle
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         p_q        <= '0;
         scan_q     <= '0;
         scan_sel_q <= 1'b0;
         lap_q      <= 8'h00;
         cnt_en_q   <= 1'b0;
         cnt_clr_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         p_q        <= p_d;
         scan_q     <= scan_d;
         scan_sel_q <= scan_sel_d;
         lap_q      <= lap_d;
         cnt_en_q   <= cnt_en_d;
         cnt_clr_q  <= cnt_clr_d;
         ovf_q      <= ovf_d;
      end
   end

   // Frozen lap value while in LAP, otherwise the live count
   assign disp = (state_q == ST_LAP) ? lap_q : bus.bcd_in;

   assign bus.cnt_en     = cnt_en_q;
   assign bus.cnt_clr    = cnt_clr_q;
   assign bus.running    = run_now;
   assign bus.lap_active = (state_q == ST_LAP);
   assign bus.disp_bcd   = disp;
   assign bus.scan_sel   = scan_sel_q;
   assign bus.scan_digit = scan_sel_q ? disp[7:4] : disp[3:0];
   assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl with TICK_DIV=4, SCAN_DIV=3.
// Stimulus queues expected (cycle, signal, value) entries; a monitor checks them each cycle.
// Inputs change 2 time units after the rising edge, outputs are sampled on the falling edge.
module tb_bcd_stopwatch_ctrl;

   localparam int S_CNT_EN  = 0;
   localparam int S_CNT_CLR = 1;
   localparam int S_RUNNING = 2;
   localparam int S_LAP_ACT = 3;
   localparam int S_DISP    = 4;
   localparam int S_SCANSEL = 5;
   localparam int S_DIGIT   = 6;
   localparam int S_OVF     = 7;

   typedef struct {
      int         cyc;
      int         sig;
      logic [7:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   done = 1'b0;
   bit   reported = 1'b0;
   exp_t sb[$];

   bcd_stopwatch_ctrl_if bus ();

   bcd_stopwatch_ctrl #(.TICK_DIV(4), .SCAN_DIV(3)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] dut_val(int s);
      case (s)
         S_CNT_EN:  return {7'd0, bus.cnt_en};
         S_CNT_CLR: return {7'd0, bus.cnt_clr};
         S_RUNNING: return {7'd0, bus.running};
         S_LAP_ACT: return {7'd0, bus.lap_active};
         S_DISP:    return bus.disp_bcd;
         S_SCANSEL: return {7'd0, bus.scan_sel};
         S_DIGIT:   return {4'd0, bus.scan_digit};
         default:   return {7'd0, bus.overflow};
      endcase
   endfunction

   function automatic string sig_name(int s);
      case (s)
         S_CNT_EN:  return "cnt_en";
         S_CNT_CLR: return "cnt_clr";
         S_RUNNING: return "running";
         S_LAP_ACT: return "lap_active";
         S_DISP:    return "disp_bcd";
         S_SCANSEL: return "scan_sel";
         S_DIGIT:   return "scan_digit";
         default:   return "overflow";
      endcase
   endfunction

   task automatic expect_at(int c, int s, logic [7:0] v);
      exp_t e;
      e.cyc = c;
      e.sig = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // Monitor: compare every expectation due this cycle, then flush leftovers at the end
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            checks++;
            if (dut_val(sb[i].sig) !== sb[i].val) begin
               failures++;
               $display("FAIL %s cyc=%0d got=%h want=%h", sig_name(sb[i].sig), cyc,
                        dut_val(sb[i].sig), sb[i].val);
            end
            sb.delete(i);
         end
      end
      if (done && !reported) begin
         foreach (sb[i]) begin
            checks++;
            failures++;
            $display("FAIL %s never sampled cyc=%0d got=none want=%h", sig_name(sb[i].sig),
                     sb[i].cyc, sb[i].val);
         end
         sb.delete();
         reported = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int c;
      logic [7:0] bcd_tab [5];
      bcd_tab = '{8'h37, 8'h38, 8'h39, 8'h40, 8'h41};

      reset          = 1'b1;
      bus.start_stop = 1'b0;
      bus.lap        = 1'b0;
      bus.clear      = 1'b0;
      bus.bcd_in     = 8'h42;

      // Reset state and digit scan of 8'h42
      do_reset();
      c = cyc;
      expect_at(c, S_CNT_EN, 8'h00);
      expect_at(c, S_CNT_CLR, 8'h00);
      expect_at(c, S_RUNNING, 8'h00);
      expect_at(c, S_LAP_ACT, 8'h00);
      expect_at(c, S_OVF, 8'h00);
      expect_at(c, S_DISP, 8'h42);
      for (int k = 0; k < 7; k++) begin
         expect_at(c + k, S_SCANSEL, (k >= 3 && k < 6) ? 8'h01 : 8'h00);
         expect_at(c + k, S_DIGIT, (k >= 3 && k < 6) ? 8'h04 : 8'h02);
      end
      repeat (7) step();

      // Start from IDLE: cnt_en at +5, +9, +13 only
      c = cyc;
      expect_at(c, S_RUNNING, 8'h00);
      expect_at(c + 1, S_RUNNING, 8'h01);
      for (int k = 1; k <= 14; k++)
         expect_at(c + k, S_CNT_EN, (k == 5 || k == 9 || k == 13) ? 8'h01 : 8'h00);
      for (int k = 0; k < 15; k++) begin
         bus.start_stop = (k == 0);
         step();
      end
      bus.start_stop = 1'b0;

      // Pause after 6 run cycles preserves the partial interval
      do_reset();
      c = cyc;
      for (int k = 1; k <= 20; k++)
         expect_at(c + k, S_CNT_EN, (k == 5 || k == 19) ? 8'h01 : 8'h00);
      expect_at(c + 10, S_RUNNING, 8'h00);
      expect_at(c + 17, S_RUNNING, 8'h01);
      for (int k = 0; k < 21; k++) begin
         bus.start_stop = (k == 0 || k == 6 || k == 16);
         step();
      end
      bus.start_stop = 1'b0;

      // Lap freezes 8'h37 while the live count moves on; second lap goes live
      c = cyc;
      expect_at(c, S_LAP_ACT, 8'h00);
      expect_at(c, S_DISP, 8'h37);
      for (int k = 1; k <= 3; k++) begin
         expect_at(c + k, S_LAP_ACT, 8'h01);
         expect_at(c + k, S_DISP, 8'h37);
      end
      expect_at(c + 4, S_LAP_ACT, 8'h00);
      expect_at(c + 4, S_DISP, 8'h41);
      expect_at(c + 4, S_RUNNING, 8'h01);
      for (int k = 0; k < 5; k++) begin
         bus.bcd_in = bcd_tab[k];
         bus.lap    = (k == 0 || k == 3);
         step();
      end
      bus.lap = 1'b0;

      // Overflow only after a cnt_en cycle with 8'h99
      do_reset();
      c = cyc;
      expect_at(c + 5, S_CNT_EN, 8'h01);
      for (int k = 1; k <= 11; k++)
         expect_at(c + k, S_OVF, (k == 6) ? 8'h01 : 8'h00);
      for (int k = 0; k < 12; k++) begin
         bus.start_stop = (k == 0);
         bus.bcd_in     = (k >= 3 && k <= 6) ? 8'h99 : 8'h98;
         step();
      end
      bus.start_stop = 1'b0;

      // Clear ignored in RUN; in PAUSE clear beats start_stop and zeroes the prescaler
      c = cyc;
      for (int k = 1; k <= 5; k++)
         expect_at(c + k, S_CNT_CLR, (k == 4) ? 8'h01 : 8'h00);
      expect_at(c + 1, S_RUNNING, 8'h01);
      expect_at(c + 2, S_RUNNING, 8'h00);
      expect_at(c + 4, S_RUNNING, 8'h00);
      expect_at(c + 6, S_RUNNING, 8'h01);
      for (int k = 1; k <= 10; k++)
         expect_at(c + k, S_CNT_EN, (k == 1 || k == 10) ? 8'h01 : 8'h00);
      for (int k = 0; k < 11; k++) begin
         bus.clear      = (k == 0 || k == 3);
         bus.start_stop = (k == 1 || k == 3 || k == 5);
         step();
      end
      bus.clear      = 1'b0;
      bus.start_stop = 1'b0;

      // Reset mid-LAP, with a pending tick and a start_stop pulse in the reset cycle
      c = cyc;
      expect_at(c + 1, S_LAP_ACT, 8'h01);
      expect_at(c + 1, S_DISP, 8'h55);
      expect_at(c + 2, S_LAP_ACT, 8'h01);
      expect_at(c + 2, S_DISP, 8'h55);
      expect_at(c + 3, S_RUNNING, 8'h00);
      expect_at(c + 3, S_LAP_ACT, 8'h00);
      expect_at(c + 3, S_CNT_EN, 8'h00);
      expect_at(c + 3, S_CNT_CLR, 8'h00);
      expect_at(c + 3, S_OVF, 8'h00);
      expect_at(c + 3, S_SCANSEL, 8'h00);
      expect_at(c + 3, S_DISP, 8'h12);
      expect_at(c + 3, S_DIGIT, 8'h02);
      expect_at(c + 4, S_RUNNING, 8'h00);
      for (int k = 0; k < 5; k++) begin
         bus.lap        = (k == 0);
         bus.bcd_in     = (k < 2) ? 8'h55 : 8'h12;
         reset          = (k == 2);
         bus.start_stop = (k == 2);
         step();
      end
      bus.lap        = 1'b0;
      bus.start_stop = 1'b0;
      reset          = 1'b0;

      repeat (2) step();
      done = 1'b1;
      wait (reported);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
